// File: rtl/mm_accumulate.sv
// Accumulate stage of the matrix dot product: sums TERMS consecutive unsigned products
// and presents each completed sum on a valid/ready output.
module mm_accumulate #(
    parameter int unsigned PRODWIDTH = 8,
    parameter int unsigned TERMS     = 4,
    localparam int unsigned SUMWIDTH = PRODWIDTH + $clog2(TERMS),
    localparam int unsigned CNTWIDTH = (TERMS > 1) ? $clog2(TERMS) : 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PRODWIDTH-1:0] in_product,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SUMWIDTH-1:0]  out_sum,
    output logic                 busy
);

    typedef enum logic [0:0] {StAccum, StDone} state_e;

    localparam logic [CNTWIDTH-1:0] LastCnt = CNTWIDTH'(TERMS - 1);

    state_e              state_q, state_d;
    logic [CNTWIDTH-1:0] count_q, count_d;
    logic [SUMWIDTH-1:0] acc_q, acc_d;
    logic [SUMWIDTH-1:0] sum_q, sum_d;
    logic                xfer;
    logic                last;

    // in_ready is a pure function of state, so the transfer is decoded from state directly
    assign xfer = in_valid && (state_q == StAccum);
    assign last = (count_q == LastCnt);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StAccum;
            count_q <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        case (state_q)
            StAccum: begin
                if (xfer) begin
                    if (last) begin
                        sum_d   = acc_q + SUMWIDTH'(in_product);
                        acc_d   = '0;
                        count_d = '0;
                        state_d = StDone;
                    end else begin
                        acc_d   = acc_q + SUMWIDTH'(in_product);
                        count_d = count_q + CNTWIDTH'(1);
                    end
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StAccum;
                end
            end
        endcase
    end

    always_comb begin
        in_ready  = (state_q == StAccum);
        out_valid = (state_q == StDone);
        busy      = (state_q == StDone) || (count_q != '0);
        out_sum   = sum_q;
    end

endmodule

// File: tb/tb_mm_accumulate.sv
// Directed bench for mm_accumulate: a TERMS=4 instance for the main scenarios and a
// TERMS=1 instance for the single-term build.
module tb_mm_accumulate;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       in_valid, in_ready, out_valid, out_ready, busy;
    logic [7:0] in_product;
    logic [9:0] out_sum;

    logic       t1_in_valid, t1_in_ready, t1_out_valid, t1_out_ready, t1_busy;
    logic [7:0] t1_in_product;
    logic [7:0] t1_out_sum;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mm_accumulate #(.PRODWIDTH(8), .TERMS(4)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_product(in_product), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .busy(busy)
    );

    mm_accumulate #(.PRODWIDTH(8), .TERMS(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .in_valid(t1_in_valid), .in_ready(t1_in_ready),
        .in_product(t1_in_product), .out_valid(t1_out_valid), .out_ready(t1_out_ready),
        .out_sum(t1_out_sum), .busy(t1_busy)
    );

    // Producer rule: a stalled offer must stay valid and unchanged until accepted.
    logic       stall_q = 1'b0;
    logic [7:0] stall_prod_q = '0;
    always @(posedge clk) begin
        if (stall_q && reset_n && (!in_valid || in_product !== stall_prod_q)) begin
            fails++;
            $display("FAIL handshake_hold: in_valid=%0b in_product=%0d required 1/%0d",
                     in_valid, in_product, stall_prod_q);
        end
        stall_q      = in_valid && !in_ready && reset_n;
        stall_prod_q = in_product;
    end

    task automatic push(input logic [7:0] p);
        logic acc;
        acc = 1'b0;
        in_valid   = 1'b1;
        in_product = p;
        for (int k = 0; k < 50 && !acc; k++) begin
            acc = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!acc) begin
            tests++; fails++;
            $display("FAIL push_timeout: product %0d not accepted, in_ready=%0b required 1",
                     p, in_ready);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0; in_valid = 1'b0; in_product = '0; out_ready = 1'b0;
        t1_in_valid = 1'b0; t1_in_product = '0; t1_out_ready = 1'b0;
        idle(3);
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready: got %0b want 1", in_ready); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid: got %0b want 0", out_valid); end
        tests++; if (out_sum !== 10'd0) begin fails++; $display("FAIL rst_out_sum: got %0d want 0", out_sum); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %0b want 0", busy); end
        tests++; if (t1_in_ready !== 1'b1 || t1_out_valid !== 1'b0) begin fails++;
            $display("FAIL rst_t1: in_ready=%0b out_valid=%0b want 1/0", t1_in_ready, t1_out_valid); end
        reset_n = 1'b1;
        idle(1);
    endtask

    task automatic test_basic_sum;
        logic [7:0] v [4] = '{8'd3, 8'd5, 8'd7, 8'd9};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push(v[i]);
            if (i < 3) begin
                tests++; if (out_valid !== 1'b0 || busy !== 1'b1) begin fails++;
                    $display("FAIL basic_early: term %0d out_valid=%0b busy=%0b want 0/1", i, out_valid, busy); end
            end
        end
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL basic_valid: got %0b want 1", out_valid); end
        tests++; if (out_sum !== 10'd24) begin fails++; $display("FAIL basic_sum: got %0d want 24", out_sum); end
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL basic_bubble: in_ready %0b want 0", in_ready); end
        idle(1);
        tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin fails++;
            $display("FAIL basic_after: out_valid=%0b in_ready=%0b busy=%0b want 0/1/0",
                     out_valid, in_ready, busy); end
    endtask

    task automatic test_max_values;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) push(8'd255);
        tests++; if (out_valid !== 1'b1 || out_sum !== 10'd1020) begin fails++;
            $display("FAIL max_sum: valid=%0b sum=%0d want 1/1020", out_valid, out_sum); end
        for (int i = 0; i < 4; i++) push(8'd0);
        tests++; if (out_valid !== 1'b1 || out_sum !== 10'd0) begin fails++;
            $display("FAIL zero_sum: valid=%0b sum=%0d want 1/0", out_valid, out_sum); end
        idle(1);
    endtask

    task automatic test_gapped_backpressure;
        logic [7:0] v [4] = '{8'd10, 8'd20, 8'd30, 8'd40};
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push(v[i]);
            if (i < 3) idle(1);
        end
        tests++; if (out_valid !== 1'b1 || out_sum !== 10'd100) begin fails++;
            $display("FAIL gapped_sum: valid=%0b sum=%0d want 1/100", out_valid, out_sum); end
        in_valid = 1'b1; in_product = 8'd1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            tests++; if (out_valid !== 1'b1 || out_sum !== 10'd100 || in_ready !== 1'b0) begin fails++;
                $display("FAIL backpressure_hold: cyc %0d valid=%0b sum=%0d in_ready=%0b want 1/100/0",
                         i, out_valid, out_sum, in_ready); end
        end
        out_ready = 1'b1;
        push(8'd1);
        push(8'd2); push(8'd3); push(8'd4);
        tests++; if (out_valid !== 1'b1 || out_sum !== 10'd10) begin fails++;
            $display("FAIL after_backpressure: valid=%0b sum=%0d want 1/10", out_valid, out_sum); end
        idle(1);
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b1;
        push(8'd50); push(8'd60);
        #2 reset_n = 1'b0;
        #1;
        tests++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin fails++;
            $display("FAIL reset_mid: valid=%0b busy=%0b in_ready=%0b want 0/0/1",
                     out_valid, busy, in_ready); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        push(8'd1); push(8'd2); push(8'd3); push(8'd4);
        tests++; if (out_valid !== 1'b1 || out_sum !== 10'd10) begin fails++;
            $display("FAIL reset_mid_sum: valid=%0b sum=%0d want 1/10", out_valid, out_sum); end
        idle(1);
    endtask

    task automatic test_reset_done;
        out_ready = 1'b0;
        push(8'd3); push(8'd5); push(8'd7); push(8'd9);
        idle(2);
        tests++; if (out_valid !== 1'b1 || out_sum !== 10'd24) begin fails++;
            $display("FAIL done_pending: valid=%0b sum=%0d want 1/24", out_valid, out_sum); end
        #2 reset_n = 1'b0;
        #1;
        tests++; if (out_valid !== 1'b0 || out_sum !== 10'd0 || busy !== 1'b0) begin fails++;
            $display("FAIL reset_done: valid=%0b sum=%0d busy=%0b want 0/0/0", out_valid, out_sum, busy); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle(1);
            tests++; if (out_valid !== 1'b0) begin fails++;
                $display("FAIL stale_result: cyc %0d valid=%0b want 0", i, out_valid); end
        end
    endtask

    task automatic test_terms1;
        t1_out_ready = 1'b1;
        t1_in_valid = 1'b1; t1_in_product = 8'd7;
        @(posedge clk); #1;
        tests++; if (t1_out_valid !== 1'b1 || t1_out_sum !== 8'd7 || t1_in_ready !== 1'b0) begin fails++;
            $display("FAIL t1_first: valid=%0b sum=%0d in_ready=%0b want 1/7/0",
                     t1_out_valid, t1_out_sum, t1_in_ready); end
        t1_in_product = 8'd200;
        @(posedge clk); #1;
        tests++; if (t1_out_valid !== 1'b0 || t1_in_ready !== 1'b1) begin fails++;
            $display("FAIL t1_bubble: valid=%0b in_ready=%0b want 0/1", t1_out_valid, t1_in_ready); end
        @(posedge clk); #1;
        t1_in_valid = 1'b0;
        tests++; if (t1_out_valid !== 1'b1 || t1_out_sum !== 8'd200) begin fails++;
            $display("FAIL t1_second: valid=%0b sum=%0d want 1/200", t1_out_valid, t1_out_sum); end
        @(posedge clk); #1;
        tests++; if (t1_out_valid !== 1'b0 || t1_busy !== 1'b0) begin fails++;
            $display("FAIL t1_idle: valid=%0b busy=%0b want 0/0", t1_out_valid, t1_busy); end
    endtask

    initial begin
        test_reset();
        test_basic_sum();
        test_max_values();
        test_gapped_backpressure();
        test_reset_mid();
        test_reset_done();
        test_terms1();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
